// File: rtl/guess_scorer.sv
// guess_scorer: scores a 4-digit, 8-colour code-breaking guess against a loaded secret.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   key_n       - raw active-low submit button, asynchronous to clk
//   secret_load - strobe that loads secret (accepted in IDLE or GAMEOVER)
//   secret      - secret code, digit p in bits [3p+2:3p]
//   guess_sw    - guess code, same packing as secret
//   guess_pulse - one-cycle pulse per scored guess
//   exact       - digits matching in value and position
//   partial     - digits matching in value only
//   busy        - high while a guess is being scored
//   win, lose   - sticky game-result flags
module guess_scorer #(
    parameter int MAX_GUESSES = 10,
    parameter int POS         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_n,
    input  logic             secret_load,
    input  logic [3*POS-1:0] secret,
    input  logic [3*POS-1:0] guess_sw,
    output logic             guess_pulse,
    output logic [2:0]       exact,
    output logic [2:0]       partial,
    output logic             busy,
    output logic             win,
    output logic             lose
);
    typedef enum logic [2:0] {IDLE, SCORE, TALLY, REPORT, GAMEOVER} state_t;

    state_t           state_q, state_d;
    logic             key_s1_q, key_s2_q, key_prev_q;
    logic             submit;
    logic [3*POS-1:0] secret_q, secret_d, guess_q, guess_d;
    logic             valid_q, valid_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       ex_acc_q, ex_acc_d, total_q, total_d;
    logic [7:0][2:0]  hg_q, hg_d, hs_q, hs_d;
    logic [2:0]       exact_q, exact_d, partial_q, partial_d;
    logic             win_q, win_d, lose_q, lose_d;
    logic [3:0]       gcount_q, gcount_d;
    logic [2:0]       dg, ds, hmin;

    // Synchronizer flops reset to 0, so a button held at release cannot fake an edge.
    assign submit = key_prev_q & ~key_s2_q;
    // cnt_q is the position index in SCORE and the colour index in TALLY.
    assign dg     = guess_q[3*cnt_q[1:0] +: 3];
    assign ds     = secret_q[3*cnt_q[1:0] +: 3];
    assign hmin   = (hg_q[cnt_q] < hs_q[cnt_q]) ? hg_q[cnt_q] : hs_q[cnt_q];

    assign guess_pulse = (state_q == REPORT);
    assign busy        = (state_q == SCORE) || (state_q == TALLY) || (state_q == REPORT);
    assign exact       = exact_q;
    assign partial     = partial_q;
    assign win         = win_q;
    assign lose        = lose_q;

    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        ex_acc_d  = ex_acc_q;
        total_d   = total_q;
        hg_d      = hg_q;
        hs_d      = hs_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        win_d     = win_q;
        lose_d    = lose_q;
        gcount_d  = gcount_q;
        case (state_q)
            IDLE, GAMEOVER: begin
                // A load outranks a same-cycle submit.
                if (secret_load) begin
                    secret_d  = secret;
                    valid_d   = 1'b1;
                    exact_d   = '0;
                    partial_d = '0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                    gcount_d  = '0;
                    state_d   = IDLE;
                end else if (state_q == IDLE && submit && valid_q) begin
                    guess_d  = guess_sw;
                    cnt_d    = '0;
                    ex_acc_d = '0;
                    total_d  = '0;
                    hg_d     = '0;
                    hs_d     = '0;
                    state_d  = SCORE;
                end
            end
            SCORE: begin
                ex_acc_d = (dg == ds) ? ex_acc_q + 3'd1 : ex_acc_q;
                hg_d[dg] = hg_q[dg] + 3'd1;
                hs_d[ds] = hs_q[ds] + 3'd1;
                cnt_d    = (cnt_q == 3'(POS - 1)) ? 3'd0 : cnt_q + 3'd1;
                state_d  = (cnt_q == 3'(POS - 1)) ? TALLY : SCORE;
            end
            TALLY: begin
                total_d = total_q + hmin;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? REPORT : TALLY;
            end
            REPORT: begin
                exact_d   = ex_acc_q;
                partial_d = total_q - ex_acc_q;
                gcount_d  = gcount_q + 4'd1;
                if (ex_acc_q == 3'd4) begin
                    win_d   = 1'b1;
                    state_d = GAMEOVER;
                end else if (gcount_d == 4'(MAX_GUESSES)) begin
                    lose_d  = 1'b1;
                    state_d = GAMEOVER;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            key_s1_q   <= 1'b0;
            key_s2_q   <= 1'b0;
            key_prev_q <= 1'b0;
            secret_q   <= '0;
            guess_q    <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            ex_acc_q   <= '0;
            total_q    <= '0;
            hg_q       <= '0;
            hs_q       <= '0;
            exact_q    <= '0;
            partial_q  <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            gcount_q   <= '0;
        end else begin
            state_q    <= state_d;
            key_s1_q   <= key_n;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            ex_acc_q   <= ex_acc_d;
            total_q    <= total_d;
            hg_q       <= hg_d;
            hs_q       <= hs_d;
            exact_q    <= exact_d;
            partial_q  <= partial_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            gcount_q   <= gcount_d;
        end
    end
endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 Parameter MAX_GUESSES, default 10, is the number of scored guesses without a win after which the game is lost.
REQ-002 Parameter POS, default 4, is the number of code positions; this revision supports only POS=4.
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port key_n, input, 1 bit: raw submit pushbutton, active-low, asynchronous to clk.
REQ-006 Port secret_load, input, 1 bit: synchronous strobe that loads secret.
REQ-007 Port secret, input, 12 bits: code as 4 digits of 3 bits each, position p in bits [3p+2:3p].
REQ-008 Port guess_sw, input, 12 bits: guess digits, packed the same way as secret.
REQ-009 Port guess_pulse, output, 1 bit: one-cycle pulse per scored guess; drives the guess-counter increment input.
REQ-010 Port exact, output, 3 bits: count of digits that match in both value and position (0-4).
REQ-011 Port partial, output, 3 bits: count of digits that match in value but not position (0-4).
REQ-012 Port busy, output, 1 bit: high while a guess is being scored.
REQ-013 Port win, output, 1 bit: sticky; high once a guess scores exact=4.
REQ-014 Port lose, output, 1 bit: sticky; high once MAX_GUESSES guesses are scored without a win.

Function
REQ-015 key_n SHALL pass through a 2-flop synchronizer; a submit event SHALL be one cycle, generated on a synchronized high-to-low transition.
REQ-016 The FSM SHALL have these states: IDLE, SCORE, TALLY, REPORT, GAMEOVER.
REQ-017 In IDLE, with a secret loaded, a submit event SHALL capture guess_sw into an internal register in that cycle and move the FSM to SCORE.
REQ-018 SCORE SHALL last exactly 4 cycles and process position i in cycle i: exact is incremented on a match, and the per-colour histograms (8 colours, 3-bit bins) of guess and secret are incremented.
REQ-019 TALLY SHALL last exactly 8 cycles and process colour c in cycle c, accumulating total += min(hist_guess[c], hist_secret[c]) in a 3-bit accumulator.
REQ-020 REPORT SHALL last 1 cycle, in which it:
- asserts guess_pulse;
- updates the exact output and sets partial = total - exact;
- increments the internal 4-bit guess count.
REQ-021 guess_pulse SHALL rise exactly 13 cycles after the capture cycle and SHALL be high for exactly 1 cycle.
REQ-022 exact and partial SHALL hold their values from the last REPORT until the next REPORT, until secret_load, or until reset.
REQ-023 busy SHALL be high in SCORE, TALLY and REPORT, and low in every other state.
REQ-024 From REPORT, the FSM SHALL go to GAMEOVER with win=1 if exact=4; otherwise to GAMEOVER with lose=1 if the guess count equals MAX_GUESSES; otherwise to IDLE.
REQ-025 Submit events in SCORE, TALLY, REPORT or GAMEOVER SHALL be ignored and not queued; changes on guess_sw after capture SHALL NOT affect the result.
REQ-026 A submit event before any secret has been loaded SHALL be ignored.
REQ-027 secret_load SHALL be accepted only in IDLE or GAMEOVER, and SHALL:
- register secret;
- set the secret-valid flag;
- clear exact, partial, win, lose and the guess count;
- move the FSM to IDLE.
REQ-028 secret_load asserted while busy SHALL be ignored.
REQ-029 If secret_load and a submit event occur in the same IDLE cycle, the load SHALL win and the submit SHALL be dropped.
REQ-030 Repeated colours SHALL be scored by the histogram-minimum rule, so exact+partial never exceeds 4.

Reset
REQ-031 While reset=0, the following SHALL be forced asynchronously to 0: the FSM (to IDLE), guess_pulse, exact, partial, busy, win, lose, the guess count, the histograms, the secret-valid flag and the synchronizer flops.
REQ-032 Reset asserted during SCORE or TALLY SHALL abort scoring with no guess_pulse; after release the block SHALL require a new secret_load.
REQ-033 After reset release, the first submit event SHALL be recognized no earlier than the third rising clk edge.

Verification
REQ-034 Load secret digits (1,2,3,4); submit guess (4,3,2,1) -> guess_pulse exactly 13 cycles after capture; exact=0, partial=4, win=0.
REQ-035 Secret (1,2,1,3), guess (1,1,2,2) -> exact=1, partial=2.
REQ-036 Secret (1,2,3,4), guess (1,2,3,4) -> exact=4, win=1, FSM in GAMEOVER; a further key press -> no guess_pulse.
REQ-037 Secret (0,0,0,0), 10 guesses of (1,1,1,1) -> 10 pulses, exact=partial=0; lose=1 after the 10th pulse; an 11th press is ignored.
REQ-038 Press key_n during TALLY, and assert reset mid-SCORE -> no extra pulse and no pulse respectively; all outputs 0 after reset.
REQ-039 Submit with no secret loaded -> no guess_pulse, busy stays 0; same-cycle secret_load and submit -> secret loaded, no scoring started.
